// File: rtl/fault_injector_multimode.sv
// Valid/ready pipeline register over N_CH codeword lines that corrupts one bit of
// one line for a programmable window of transactions (stuck-at-0/1 or bit-flip).
module fault_injector_multimode #(
    parameter int          W         = 29,
    parameter int          N_CH      = 10,
    parameter int          IDX_W     = $clog2(W),
    parameter int          CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_CH*W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [N_CH*W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    input  logic [1:0]        cfg_mode,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [IDX_W-1:0]  cfg_bit,
    input  logic              cfg_rand,
    input  logic [15:0]       cfg_delay,
    input  logic [15:0]       cfg_len,
    input  logic              arm,
    input  logic              disarm,
    output logic              fault_active,
    output logic              done,
    output logic [31:0]       inj_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        INJECT = 2'd2,
        DONE   = 2'd3
    } state_t;

    // One extra bit so W and N_CH are representable even when they are powers of two.
    localparam logic [IDX_W:0] W_EXT    = (IDX_W+1)'(W);
    localparam logic [CH_W:0]  N_CH_EXT = (CH_W+1)'(N_CH);

    state_t             state;
    state_t             state_n;
    logic [15:0]        dcnt;
    logic [15:0]        dcnt_n;
    logic [15:0]        lcnt;
    logic [15:0]        lcnt_n;

    logic [1:0]         mode_q;
    logic [CH_W-1:0]    ch_q;
    logic [IDX_W-1:0]   bit_q;
    logic               rand_q;
    logic [15:0]        len_q;

    logic [15:0]        lfsr;
    logic               lfsr_fb;
    logic [IDX_W:0]     idx_wide;
    logic [IDX_W-1:0]   lfsr_idx;
    logic [IDX_W-1:0]   bit_sel;
    logic               bit_ok;
    logic               ch_ok;
    logic [W-1:0]       bit_mask;
    logic               xfer;
    logic [N_CH*W-1:0]  corrupt_data;

    assign in_ready     = !out_valid || out_ready;
    assign xfer         = in_valid && in_ready;
    assign fault_active = (state == INJECT);
    assign done         = (state == DONE);

    // Disarm beats arm; an arm always restarts from the incoming configuration.
    always_comb begin
        state_n = state;
        dcnt_n  = dcnt;
        lcnt_n  = lcnt;
        if (disarm) begin
            state_n = IDLE;
        end else if (arm) begin
            if (cfg_mode == 2'd0) begin
                state_n = IDLE;
            end else if (cfg_delay == 16'd0) begin
                state_n = INJECT;
                lcnt_n  = cfg_len;
            end else begin
                state_n = ARMED;
                dcnt_n  = cfg_delay;
            end
        end else begin
            case (state)
                ARMED: begin
                    if (xfer) begin
                        dcnt_n = dcnt - 16'd1;
                        if (dcnt <= 16'd1) begin
                            state_n = INJECT;
                            lcnt_n  = len_q;
                        end
                    end
                end
                INJECT: begin
                    if (xfer && (len_q != 16'd0)) begin
                        lcnt_n = lcnt - 16'd1;
                        if (lcnt <= 16'd1) begin
                            state_n = DONE;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            dcnt  <= 16'd0;
            lcnt  <= 16'd0;
        end else begin
            state <= state_n;
            dcnt  <= dcnt_n;
            lcnt  <= lcnt_n;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q <= 2'd0;
            ch_q   <= '0;
            bit_q  <= '0;
            rand_q <= 1'b0;
            len_q  <= 16'd0;
        end else if (arm && !disarm) begin
            mode_q <= cfg_mode;
            ch_q   <= cfg_ch;
            bit_q  <= cfg_bit;
            rand_q <= cfg_rand;
            len_q  <= cfg_len;
        end
    end

    // Fibonacci LFSR, taps 16,14,13,11; steps once per accepted transaction.
    assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr <= LFSR_SEED;
        end else if (xfer) begin
            lfsr <= {lfsr[14:0], lfsr_fb};
        end
    end

    // Folding once is enough because 2^IDX_W < 2W.
    always_comb begin
        idx_wide = {1'b0, lfsr[IDX_W-1:0]};
        if (idx_wide >= W_EXT) begin
            idx_wide = idx_wide - W_EXT;
        end
        lfsr_idx = idx_wide[IDX_W-1:0];
    end

    assign bit_sel  = rand_q ? lfsr_idx : bit_q;
    assign bit_ok   = ({1'b0, bit_sel} < W_EXT);
    assign ch_ok    = ({1'b0, ch_q} < N_CH_EXT);
    assign bit_mask = W'(1) << bit_sel;

    always_comb begin
        corrupt_data = in_data;
        if ((state == INJECT) && bit_ok && ch_ok) begin
            for (int k = 0; k < N_CH; k++) begin
                if (ch_q == CH_W'(k)) begin
                    case (mode_q)
                        2'd1:    corrupt_data[k*W +: W] = in_data[k*W +: W] & ~bit_mask;
                        2'd2:    corrupt_data[k*W +: W] = in_data[k*W +: W] | bit_mask;
                        2'd3:    corrupt_data[k*W +: W] = in_data[k*W +: W] ^ bit_mask;
                        default: corrupt_data[k*W +: W] = in_data[k*W +: W];
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data  <= '0;
            out_valid <= 1'b0;
        end else if (xfer) begin
            out_data  <= corrupt_data;
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Out-of-range targets still count: the window advanced even if nothing flipped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inj_count <= 32'd0;
        end else if (xfer && (state == INJECT) && (inj_count != 32'hFFFF_FFFF)) begin
            inj_count <= inj_count + 32'd1;
        end
    end

endmodule
